// File: rtl/aes128_enc_iter_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, on-the-fly key expansion, valid/ready on both sides.
// Optional macro AES_ENC_ABORT_EN adds an abort input that returns the engine to IDLE from ROUND or DONE.
module aes128_enc_iter_ctrl #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_ENC_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [3:0] LAST_RND = 4'(ROUNDS);

  logic [1:0]   fsm_q;
  logic [127:0] st_q;
  logic [127:0] rk_q;
  logic [3:0]   rnd_q;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 by an addition chain; 0 maps to 0 naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x14  = gf_mul(x12, x2);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    return gf_mul(x240, x14);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [127:0] rk_next;
  logic [127:0] sr_out;
  logic [127:0] st_next;
  logic         last_rnd;
  logic         abort_hit;

  assign rk_next  = key_expand(rk_q, rcon(rnd_q));
  assign sr_out   = shift_rows(sub_bytes(st_q));
  assign last_rnd = (rnd_q == LAST_RND);
  assign st_next  = (last_rnd ? sr_out : mix_columns(sr_out)) ^ rk_next;

`ifdef AES_ENC_ABORT_EN
  assign abort_hit = abort && (fsm_q != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= S_IDLE;
      st_q  <= '0;
      rk_q  <= '0;
      rnd_q <= '0;
    end else if (abort_hit) begin
      fsm_q <= S_IDLE;
      st_q  <= '0;
      rk_q  <= '0;
      rnd_q <= '0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (in_valid) begin
            st_q  <= in_data ^ in_key;
            rk_q  <= in_key;
            rnd_q <= 4'd1;
            fsm_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          st_q  <= st_next;
          rk_q  <= rk_next;
          rnd_q <= rnd_q + 4'd1;
          if (last_rnd) fsm_q <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) fsm_q <= S_IDLE;
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  // The state register holds the ciphertext untouched while DONE waits for the consumer.
  assign in_ready  = (fsm_q == S_IDLE);
  assign out_valid = (fsm_q == S_DONE);
  assign busy      = (fsm_q == S_ROUND) || (fsm_q == S_DONE);
  assign out_data  = st_q;

endmodule

// File: tb/tb_aes128_enc_iter_ctrl.sv
// Scoreboard bench for aes128_enc_iter_ctrl: FIPS vectors, backpressure, back-to-back, reset, random blocks.
module tb_aes128_enc_iter_ctrl;
  localparam int R = 10;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk;
  logic         rst_n;
  logic         abort;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_key;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   sb[256];

  aes128_enc_iter_ctrl #(.ROUNDS(R)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef AES_ENC_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_key(in_key),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errs++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // S-box generated from the generator-3 log walk, independent of any inversion circuit.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    repeat (255) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end
    sb[0] = 8'h63;
  endtask

  function automatic logic [7:0] mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Textbook cipher on a 4x4 byte matrix with a fully precomputed key schedule.
  function automatic logic [127:0] ref_enc(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w[44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   s[4][4];
    logic [7:0]   t[4][4];
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = mul2(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = p[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rd = 1; rd <= R; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sb[s[r][(c+r)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (rd < R)
            s[r][c] = mul2(t[r][c]) ^ mul2(t[(r+1)%4][c]) ^ t[(r+1)%4][c]
                      ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] = s[r][c] ^ w[4*rd+c][31-8*r -: 8];
    end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  // Monitor: every completed output handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !abort) begin
      if (exp_q.size() == 0) fail("unexpected_output");
      else check("ciphertext", out_data, exp_q.pop_front());
    end
  end

  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [127:0] k, input logic [127:0] p);
    int n;
    n = 0;
    in_key   = k;
    in_data  = p;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail("accept_timeout");
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input bit rand_ready);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    if (exp_q.size() != 0) fail("drain_timeout");
  endtask

  task automatic wait_out_valid(output int cnt);
    cnt = 0;
    while (cnt < 50) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      cnt++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, bad, acc, n;
    int t_acc[2];
    logic [127:0] k, p;

    build_sbox();
    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_key = '0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // C.1 with latency measurement and backpressure
    exp_q.push_back(C1_CT);
    send(C1_KEY, C1_PT);
    wait_out_valid(lat);
    check("latency", lat, R);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i % 3 == 0) && (i < 18);
      in_key   = {$urandom, $urandom, $urandom, $urandom};
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      if (out_data !== C1_CT || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) bad++;
    end
    check("bp_hold_cycles_bad", bad, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("idle_after_hs_in_ready", in_ready, 1);
    check("idle_after_hs_out_valid", out_valid, 0);
    check("idle_after_hs_busy", busy, 0);
    check("bp_queue_empty", exp_q.size(), 0);

    // App B
    exp_q.push_back(B_CT);
    send(B_KEY, B_PT);
    drain(1'b0);
    @(posedge clk);
    #1 out_ready = 1'b0;

    // back-to-back: in_valid and out_ready held high
    out_ready = 1'b1;
    in_key = C1_KEY; in_data = C1_PT; in_valid = 1'b1;
    acc = 0; n = 0;
    while (acc < 2 && n < 100) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(C1_CT);
        t_acc[acc] = cyc;
        acc++;
      end
      @(posedge clk);
      #1 if (acc == 2) in_valid = 1'b0;
      n++;
    end
    if (acc < 2) begin
      in_valid = 1'b0;
      fail("b2b_accept_timeout");
    end else check("b2b_gap", t_acc[1] - t_acc[0], R + 2);
    drain(1'b0);
    @(posedge clk);
    #1 out_ready = 1'b0;

    // asynchronous reset mid-operation: block discarded
    send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_data", out_data, 0);
    check("midrst_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.push_back(C1_CT);
    send(C1_KEY, C1_PT);
    drain(1'b0);

`ifdef AES_ENC_ABORT_EN
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(C1_KEY, C1_PT);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_round_in_ready", in_ready, 1);
    check("abort_round_busy", busy, 0);
    check("abort_round_out_data", out_data, 0);
    repeat (15) @(posedge clk);
    check("abort_round_no_output", out_valid, 0);
    #1 out_ready = 1'b0;
    send(B_KEY, B_PT);
    wait_out_valid(lat);
    check("abort_done_latency", lat, R);
    @(posedge clk);
    #1 begin abort = 1'b1; out_ready = 1'b1; end
    @(posedge clk);
    #1 begin abort = 1'b0; out_ready = 1'b0; end
    check("abort_done_out_valid", out_valid, 0);
    check("abort_done_in_ready", in_ready, 1);
`endif

    // randomized blocks with random consumer stalls
    for (int b = 0; b < 8; b++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(ref_enc(k, p));
      send(k, p);
      drain(1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 out_ready = 1'b0;
    end

    repeat (3) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
